// File: rtl/ac97_pkg.sv
// Shared AC97 definitions: register map, init values, scheduler states and
// the power-up init table replayed after every codec-ready assertion.
package ac97_pkg;

   localparam int AC97_ADDR_W = 7;
   localparam int AC97_DATA_W = 16;
   localparam int IDX_W       = 4;
   localparam int CNT_W       = 4;

   localparam logic [AC97_ADDR_W-1:0] AC97_REG_MASTER = 7'h02;
   localparam logic [AC97_ADDR_W-1:0] AC97_REG_LINEIN = 7'h10;
   localparam logic [AC97_ADDR_W-1:0] AC97_REG_RECSRC = 7'h1A;

   localparam logic [AC97_DATA_W-1:0] AC97_RECSRC_LINEIN = 16'h0404;
   localparam logic [AC97_DATA_W-1:0] AC97_LINEIN_VOL    = 16'h0808;
   localparam logic [AC97_DATA_W-1:0] AC97_MASTER_VOL    = 16'h0000;

   typedef enum logic [2:0] {
      ST_WAIT_RDY,
      ST_INIT,
      ST_IDLE,
      ST_ISSUE,
      ST_RD_WAIT
   } sched_state_t;

   typedef struct packed {
      logic [AC97_ADDR_W-1:0] addr;
      logic [AC97_DATA_W-1:0] data;
   } init_entry_t;

   localparam int INIT_TABLE_LEN = 3;

   localparam init_entry_t [0:INIT_TABLE_LEN-1] INIT_TABLE = '{
      '{addr: AC97_REG_RECSRC, data: AC97_RECSRC_LINEIN},
      '{addr: AC97_REG_LINEIN, data: AC97_LINEIN_VOL},
      '{addr: AC97_REG_MASTER, data: AC97_MASTER_VOL}
   };

endpackage

// File: rtl/ac97_cmd_scheduler_if.sv
// Bundles the frame-engine side (cmd/status slots) and the user request side
// of the AC97 command scheduler. master = scheduler, slave = its surroundings.
interface ac97_cmd_scheduler_if;
   import ac97_pkg::*;

   logic                   frame_start;
   logic                   codec_ready;
   logic                   sts_valid;
   logic [AC97_ADDR_W-1:0] sts_addr;
   logic [AC97_DATA_W-1:0] sts_data;

   logic                   cmd_valid;
   logic                   cmd_rw;
   logic [AC97_ADDR_W-1:0] cmd_addr;
   logic [AC97_DATA_W-1:0] cmd_data;

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_rw;
   logic [AC97_ADDR_W-1:0] req_addr;
   logic [AC97_DATA_W-1:0] req_wdata;

   logic                   rsp_valid;
   logic [AC97_DATA_W-1:0] rsp_data;
   logic                   rsp_timeout;
   logic                   init_done;

   modport master (
      input  frame_start, codec_ready, sts_valid, sts_addr, sts_data,
      input  req_valid, req_rw, req_addr, req_wdata,
      output cmd_valid, cmd_rw, cmd_addr, cmd_data,
      output req_ready, rsp_valid, rsp_data, rsp_timeout, init_done
   );

   modport slave (
      output frame_start, codec_ready, sts_valid, sts_addr, sts_data,
      output req_valid, req_rw, req_addr, req_wdata,
      input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
      input  req_ready, rsp_valid, rsp_data, rsp_timeout, init_done
   );

endinterface

// File: rtl/ac97_init_rom.sv
// Combinational lookup into the init table; indices past the table read as 0.
module ac97_init_rom
   import ac97_pkg::*;
(
   input  logic [IDX_W-1:0]       idx,
   output logic [AC97_ADDR_W-1:0] addr,
   output logic [AC97_DATA_W-1:0] data
);

   // Select the table entry whose position matches idx
   always_comb begin
      addr = '0;
      data = '0;
      for (int i = 0; i < INIT_TABLE_LEN; i++) begin
         if (idx == IDX_W'(i)) begin
            addr = INIT_TABLE[i].addr;
            data = INIT_TABLE[i].data;
         end
      end
   end

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// Serialises all AC97 register traffic: replays the init table after codec
// ready, then issues one user read/write per frame and matches read replies.
module ac97_cmd_scheduler
   import ac97_pkg::*;
#(
   parameter int READ_TIMEOUT_FRAMES = 4,
   parameter int INIT_LEN            = 3
)
(
   input  logic                  fclk,
   input  logic                  freset,
   ac97_cmd_scheduler_if.master  bus
);

   localparam logic [IDX_W-1:0] INIT_LAST    = IDX_W'(INIT_LEN - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READ_TIMEOUT_FRAMES - 1);

   sched_state_t           state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic                   cmd_rw_q, cmd_rw_d;
   logic [AC97_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [AC97_DATA_W-1:0] cmd_data_q, cmd_data_d;
   logic                   req_ready_q, req_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [AC97_DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic                   rsp_timeout_q, rsp_timeout_d;
   logic                   init_done_q, init_done_d;

   logic                   consume, rdy_lost, accept, sts_match, timeout_hit;
   logic [IDX_W-1:0]       rom_idx;
   logic [AC97_ADDR_W-1:0] rom_addr;
   logic [AC97_DATA_W-1:0] rom_data;

   ac97_init_rom u_rom (
      .idx  (rom_idx),
      .addr (rom_addr),
      .data (rom_data)
   );

   // Event qualifiers shared by the next-state and output logic
   always_comb begin
      consume     = bus.frame_start & cmd_valid_q;
      rdy_lost    = ~bus.codec_ready & (state_q != ST_WAIT_RDY);
      accept      = bus.req_valid & req_ready_q & (state_q == ST_IDLE);
      sts_match   = bus.sts_valid & (bus.sts_addr == cmd_addr_q);
      timeout_hit = bus.frame_start & (cnt_q == TIMEOUT_LAST);
      rom_idx     = (state_q == ST_INIT) ? idx_q + IDX_W'(1) : idx_q;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge fclk) begin
      if (freset) begin
         state_q       <= ST_WAIT_RDY;
         idx_q         <= '0;
         cnt_q         <= '0;
         cmd_valid_q   <= 1'b0;
         cmd_rw_q      <= 1'b0;
         cmd_addr_q    <= '0;
         cmd_data_q    <= '0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         init_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_rw_q      <= cmd_rw_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_data_q    <= cmd_data_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         init_done_q   <= init_done_d;
      end
   end

   // Next-state: losing codec ready overrides everything else
   always_comb begin
      state_d = state_q;
      if (rdy_lost) begin
         state_d = ST_WAIT_RDY;
      end else begin
         case (state_q)
            ST_WAIT_RDY: if (bus.codec_ready) state_d = ST_INIT;
            ST_INIT:     if (consume && idx_q == INIT_LAST) state_d = ST_IDLE;
            ST_IDLE:     if (accept) state_d = ST_ISSUE;
            ST_ISSUE:    if (consume) state_d = cmd_rw_q ? ST_RD_WAIT : ST_IDLE;
            ST_RD_WAIT:  if (sts_match || timeout_hit) state_d = ST_IDLE;
            default:     state_d = ST_WAIT_RDY;
         endcase
      end
   end

   // Output/datapath: command loading, frame counting and response pulses
   always_comb begin
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      cmd_valid_d   = cmd_valid_q;
      cmd_rw_d      = cmd_rw_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_data_d    = cmd_data_q;
      rsp_valid_d   = 1'b0;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      init_done_d   = init_done_q;
      req_ready_d   = (state_d == ST_IDLE);
      if (rdy_lost) begin
         cmd_valid_d = 1'b0;
         init_done_d = 1'b0;
         idx_d       = '0;
         if (state_q == ST_ISSUE || state_q == ST_RD_WAIT) begin
            rsp_valid_d   = 1'b0 | 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_data_d    = '0;
         end
      end else begin
         case (state_q)
            ST_WAIT_RDY: begin
               idx_d = '0;
               if (bus.codec_ready) begin
                  cmd_valid_d = 1'b1;
                  cmd_rw_d    = 1'b0;
                  cmd_addr_d  = rom_addr;
                  cmd_data_d  = rom_data;
               end
            end
            ST_INIT: begin
               if (consume) begin
                  if (idx_q == INIT_LAST) begin
                     cmd_valid_d = 1'b0;
                     init_done_d = 1'b1;
                     idx_d       = '0;
                  end else begin
                     idx_d      = rom_idx;
                     cmd_addr_d = rom_addr;
                     cmd_data_d = rom_data;
                  end
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  cmd_valid_d = 1'b1;
                  cmd_rw_d    = bus.req_rw;
                  cmd_addr_d  = bus.req_addr;
                  cmd_data_d  = bus.req_rw ? '0 : bus.req_wdata;
               end
            end
            ST_ISSUE: begin
               if (consume) begin
                  cmd_valid_d = 1'b0;
                  cnt_d       = '0;
                  if (!cmd_rw_q) begin
                     rsp_valid_d   = 1'b1;
                     rsp_timeout_d = 1'b0;
                     rsp_data_d    = '0;
                  end
               end
            end
            ST_RD_WAIT: begin
               if (sts_match) begin
                  rsp_valid_d   = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_data_d    = bus.sts_data;
               end else if (bus.frame_start) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (timeout_hit) begin
                     rsp_valid_d   = 1'b1;
                     rsp_timeout_d = 1'b1;
                     rsp_data_d    = '0;
                  end
               end
            end
            default: begin
               cmd_valid_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_valid   = cmd_valid_q;
   assign bus.cmd_rw      = cmd_rw_q;
   assign bus.cmd_addr    = cmd_addr_q;
   assign bus.cmd_data    = cmd_data_q;
   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.init_done   = init_done_q;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Self-checking bench for ac97_cmd_scheduler: init replay, writes, reads with
// decoy/late/missing replies, codec-ready loss and mid-operation reset.
module tb_ac97_cmd_scheduler;

   localparam int TO = 4;

   // Expected init commands packed as {rw, addr, data}
   localparam logic [23:0] EXP_INIT0 = 24'h1A_0404;
   localparam logic [23:0] EXP_INIT1 = 24'h10_0808;
   localparam logic [23:0] EXP_INIT2 = 24'h02_0000;

   logic fclk = 1'b0;
   logic freset;
   int   total = 0;
   int   bad   = 0;

   // Free-running 100 MHz clock
   always #5 fclk = ~fclk;

   ac97_cmd_scheduler_if bus ();

   ac97_cmd_scheduler #(
      .READ_TIMEOUT_FRAMES (TO),
      .INIT_LEN            (3)
   ) dut (
      .fclk   (fclk),
      .freset (freset),
      .bus    (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of frame/status strobes, then sample #1 after the edge
   task automatic applyStimulus(input logic fs, input logic sv, input logic [6:0] sa, input logic [15:0] sd);
      bus.frame_start = fs;
      bus.sts_valid   = sv;
      bus.sts_addr    = sa;
      bus.sts_data    = sd;
      @(posedge fclk);
      #1;
      bus.frame_start = 1'b0;
      bus.sts_valid   = 1'b0;
   endtask

   task automatic quietCycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 7'h0, 16'h0);
         checkOutput(tag, {31'd0, bus.rsp_valid}, 32'd0);
      end
   endtask

   // Frame strobe; reports the command that was presented to it
   task automatic frameTick(output logic cv, output logic [23:0] cmd);
      cv  = bus.cmd_valid;
      cmd = {bus.cmd_rw, bus.cmd_addr, bus.cmd_data};
      applyStimulus(1'b1, 1'b0, 7'h0, 16'h0);
   endtask

   task automatic doInit(input int gapFixed);
      logic        cv;
      logic [23:0] c;
      logic [23:0] expv;
      int          gap;
      bus.codec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         gap  = (gapFixed > 0) ? gapFixed : int'($urandom_range(2, 12));
         expv = (k == 0) ? EXP_INIT0 : (k == 1) ? EXP_INIT1 : EXP_INIT2;
         quietCycles(gap, "init_quiet");
         checkOutput("init_done_early", {31'd0, bus.init_done}, 32'd0);
         frameTick(cv, c);
         checkOutput("init_cmd_valid", {31'd0, cv}, 32'd1);
         checkOutput($sformatf("init_cmd%0d", k), {8'd0, c}, {8'd0, expv});
      end
      checkOutput("init_done", {31'd0, bus.init_done}, 32'd1);
      checkOutput("init_req_ready", {31'd0, bus.req_ready}, 32'd1);
   endtask

   // Present a request and wait (bounded) for acceptance; ok=0 on expiry
   task automatic acceptReq(input logic rw, input logic [6:0] addr, input logic [15:0] wdata,
                            input logic accFrame, output bit ok);
      int waitc = 0;
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      while (!bus.req_ready && waitc < 50) begin
         applyStimulus(1'b0, 1'b0, 7'h0, 16'h0);
         waitc++;
      end
      checkOutput("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
      ok = bus.req_ready;
      if (ok) begin
         applyStimulus(accFrame, 1'b0, 7'h0, 16'h0);
         checkOutput("acc_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
         checkOutput("acc_req_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic doRequest(input logic rw, input logic [6:0] addr, input logic [15:0] wdata,
                            input int replyFrame, input bit coincide, input bit decoy,
                            input logic [15:0] rdData, input logic accFrame);
      logic        cv;
      logic [23:0] c;
      bit          ok;
      bit          done;
      acceptReq(rw, addr, wdata, accFrame, ok);
      if (!ok) return;
      quietCycles($urandom_range(0, 6), "issue_quiet");
      frameTick(cv, c);
      checkOutput("issue_cmd_valid", {31'd0, cv}, 32'd1);
      checkOutput("issue_cmd", {8'd0, c}, {8'd0, rw, addr, (rw ? 16'h0 : wdata)});
      if (!rw) begin
         checkOutput("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         checkOutput("wr_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
         checkOutput("wr_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
      end else begin
         checkOutput("rd_no_early_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         done = 1'b0;
         if (decoy) begin
            applyStimulus(1'b0, 1'b1, addr ^ 7'h11, 16'($urandom));
            checkOutput("decoy_ignored", {31'd0, bus.rsp_valid}, 32'd0);
         end
         for (int f = 1; f <= TO && !done; f++) begin
            quietCycles($urandom_range(0, 5), "rd_quiet");
            if (f == replyFrame) begin
               applyStimulus(coincide, 1'b1, addr, rdData);
               checkOutput("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
               checkOutput("rd_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
               checkOutput("rd_rsp_data", {16'd0, bus.rsp_data}, {16'd0, rdData});
               done = 1'b1;
            end else begin
               applyStimulus(1'b1, 1'b0, 7'h0, 16'h0);
               if (f == TO) begin
                  checkOutput("to_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
                  checkOutput("to_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
                  checkOutput("to_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
               end else begin
                  checkOutput("rd_wait_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
               end
            end
         end
      end
      applyStimulus(1'b0, 1'b0, 7'h0, 16'h0);
      checkOutput("rsp_pulse_width", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("back_to_idle", {31'd0, bus.req_ready}, 32'd1);
   endtask

   // Drop codec_ready while a request is outstanding (consumed=1: in read wait)
   task automatic dropReady(input logic rw, input bit consumed);
      logic        cv;
      logic [23:0] c;
      bit          ok;
      acceptReq(rw, 7'($urandom), 16'($urandom), 1'b0, ok);
      if (!ok) return;
      if (consumed) begin
         frameTick(cv, c);
         quietCycles($urandom_range(0, 2), "drop_quiet");
      end
      bus.codec_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 7'h0, 16'h0);
      checkOutput("drop_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("drop_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
      checkOutput("drop_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
      checkOutput("drop_init_done", {31'd0, bus.init_done}, 32'd0);
      checkOutput("drop_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
      checkOutput("drop_req_ready", {31'd0, bus.req_ready}, 32'd0);
      applyStimulus(1'b1, 1'b0, 7'h0, 16'h0);
      checkOutput("drop_pulse_width", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("drop_stays_idle", {31'd0, bus.cmd_valid}, 32'd0);
      doInit(0);
   endtask

   // Bound the whole run
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin
      logic        cv;
      logic [23:0] c;
      bit          ok;
      bus.frame_start = 1'b0;
      bus.codec_ready = 1'b0;
      bus.sts_valid   = 1'b0;
      bus.sts_addr    = '0;
      bus.sts_data    = '0;
      bus.req_valid   = 1'b0;
      bus.req_rw      = 1'b0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      freset          = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b0, 7'h0, 16'h0);
      checkOutput("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
      checkOutput("rst_cmd", {8'd0, bus.cmd_rw, bus.cmd_addr, bus.cmd_data}, 32'd0);
      checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("rst_rsp", {14'd0, bus.rsp_valid, bus.rsp_timeout, bus.rsp_data}, 32'd0);
      checkOutput("rst_init_done", {31'd0, bus.init_done}, 32'd0);
      freset = 1'b0;
      repeat (3) applyStimulus(1'b1, 1'b0, 7'h0, 16'h0);
      checkOutput("no_ready_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);

      doInit(255);

      doRequest(1'b0, 7'h18, 16'h1F1F, 0, 1'b0, 1'b0, 16'h0, 1'b0);
      doRequest(1'b1, 7'h26, 16'h0, 1, 1'b0, 1'b1, 16'h000F, 1'b0);
      doRequest(1'b1, 7'h7C, 16'h0, TO + 1, 1'b0, 1'b0, 16'h0, 1'b0);
      doRequest(1'b1, 7'h26, 16'h0, TO, 1'b1, 1'b0, 16'hBEEF, 1'b1);

      dropReady(1'b1, 1'b1);
      dropReady(1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         doRequest(1'($urandom), 7'($urandom), 16'($urandom), int'($urandom_range(1, TO + 1)),
                   1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      acceptReq(1'b1, 7'h2C, 16'h0, 1'b0, ok);
      if (ok) frameTick(cv, c);
      freset = 1'b1;
      applyStimulus(1'b0, 1'b1, 7'h2C, 16'h1234);
      checkOutput("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("midrst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
      checkOutput("midrst_init_done", {31'd0, bus.init_done}, 32'd0);
      checkOutput("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      freset = 1'b0;
      doInit(0);
      doRequest(1'b0, 7'h02, 16'h8000, 0, 1'b0, 1'b0, 16'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
